buttons_res: RTL and testbench

Request-latching block for the elevator controller. Captures cabin (inside) floor-button presses and hall (outside) up/down call-button presses. Holds each as an active request until the controller cancels it by asserting the matching inactivate bit, normally when the car serves that floor and direction. It sits between the raw button inputs and the elevator scheduling FSM.

---
 rtl/buttons_pkg.sv | 9 +
 rtl/btn_latch_bank.sv | 45 ++++
 rtl/buttons_res.sv | 56 +++++
 tb/tb_buttons_res.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/buttons_pkg.sv
// buttons_pkg: constants shared by the request-latching block.
//   BUTTONS_WIDTH_DEFAULT : default number of floors
//   BUTTONS_WIDTH_MIN     : smallest legal floor count (checked at elaboration)
package buttons_pkg;

  localparam int BUTTONS_WIDTH_DEFAULT = 8;
  localparam int BUTTONS_WIDTH_MIN     = 2;

endpackage

// File: rtl/btn_latch_bank.sv
// btn_latch_bank: N independent set/clear request flags.
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high
//   btn    : per-bit set request
//   clr    : per-bit clear request (wins over btn)
//   active : registered flag outputs
// Optional feature macro: BUTTONS_RES_EDGE_EN
//   defined   -> a flag is set only on a 0->1 transition of its button
//   undefined -> a flag is set whenever its button is high
module btn_latch_bank #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] btn,
  input  logic [N-1:0] clr,
  output logic [N-1:0] active
);

  logic [N-1:0] set_req;
  logic [N-1:0] flags;

`ifdef BUTTONS_RES_EDGE_EN
  logic [N-1:0] btn_prev;

  always_ff @(posedge clk) begin
    if (reset) btn_prev <= '0;
    else       btn_prev <= btn;
  end

  // A button held through a clear must be released before it can set again.
  assign set_req = btn & ~btn_prev;
`else
  assign set_req = btn;
`endif

  // Clear dominates set for the same bit in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) flags <= '0;
    else       flags <= (flags | set_req) & ~clr;
  end

  assign active = flags;

endmodule

// File: rtl/buttons_res.sv
// buttons_res: latches cabin and hall call requests until the scheduler
// cancels them. Bit index of every vector is the floor number.
//   clk, reset                  : clock, synchronous active-high reset
//   btn_in / active_in_levels   : cabin buttons / requests, floors W-1..0
//   btn_up_out / active_out_up_levels     : hall up, floors W-2..0
//   btn_down_out / active_out_down_levels : hall down, floors W-1..1
//   inactivate_*                : per-floor request clears
// Optional feature macro: BUTTONS_RES_EDGE_EN (edge-triggered set).
module buttons_res
  import buttons_pkg::*;
#(
  parameter int BUTTONS_WIDTH = BUTTONS_WIDTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [BUTTONS_WIDTH-1:0] btn_in,
  input  logic [BUTTONS_WIDTH-2:0] btn_up_out,
  input  logic [BUTTONS_WIDTH-1:1] btn_down_out,
  input  logic [BUTTONS_WIDTH-1:0] inactivate_in_levels,
  input  logic [BUTTONS_WIDTH-2:0] inactivate_out_up_levels,
  input  logic [BUTTONS_WIDTH-1:1] inactivate_out_down_levels,
  output logic [BUTTONS_WIDTH-1:0] active_in_levels,
  output logic [BUTTONS_WIDTH-2:0] active_out_up_levels,
  output logic [BUTTONS_WIDTH-1:1] active_out_down_levels
);

  if (BUTTONS_WIDTH < BUTTONS_WIDTH_MIN) begin : g_width_check
    $error("buttons_res: BUTTONS_WIDTH must be at least %0d", BUTTONS_WIDTH_MIN);
  end

  btn_latch_bank #(.N(BUTTONS_WIDTH)) u_in_bank (
    .clk    (clk),
    .reset  (reset),
    .btn    (btn_in),
    .clr    (inactivate_in_levels),
    .active (active_in_levels)
  );

  btn_latch_bank #(.N(BUTTONS_WIDTH-1)) u_up_bank (
    .clk    (clk),
    .reset  (reset),
    .btn    (btn_up_out),
    .clr    (inactivate_out_up_levels),
    .active (active_out_up_levels)
  );

  // Down bank is numbered from floor 1; the part-selects shift it to bank bit 0.
  btn_latch_bank #(.N(BUTTONS_WIDTH-1)) u_down_bank (
    .clk    (clk),
    .reset  (reset),
    .btn    (btn_down_out[BUTTONS_WIDTH-1:1]),
    .clr    (inactivate_out_down_levels[BUTTONS_WIDTH-1:1]),
    .active (active_out_down_levels[BUTTONS_WIDTH-1:1])
  );

endmodule

// File: tb/tb_buttons_res.sv
module tb_buttons_res;
  localparam int W = 8;

  logic         clk = 0;
  logic         reset;
  logic [7:0]   btn_in, clr_in, act_in;
  logic [6:0]   btn_up, clr_up, act_up;
  logic [7:1]   btn_dn, clr_dn, act_dn;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 0;

  // Per-floor request records and previous button samples.
  bit m_in[W], m_up[W], m_dn[W];
  bit p_in[W], p_up[W], p_dn[W];

  buttons_res #(.BUTTONS_WIDTH(W)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .btn_in                     (btn_in),
    .btn_up_out                 (btn_up),
    .btn_down_out               (btn_dn),
    .inactivate_in_levels       (clr_in),
    .inactivate_out_up_levels   (clr_up),
    .inactivate_out_down_levels (clr_dn),
    .active_in_levels           (act_in),
    .active_out_up_levels       (act_up),
    .active_out_down_levels     (act_dn)
  );

  always #5 clk = ~clk;

  function automatic bit pressed(bit cur, bit prev);
`ifdef BUTTONS_RES_EDGE_EN
    return cur && !prev;
`else
    return cur;
`endif
  endfunction

  function automatic bit req_next(bit q, bit rst, bit press, bit cancel);
    if (rst)    return 1'b0;
    if (cancel) return 1'b0;
    if (press)  return 1'b1;
    return q;
  endfunction

  always @(posedge clk) begin
    for (int f = 0; f < W; f++) begin
      m_in[f] = req_next(m_in[f], reset, pressed(btn_in[f], p_in[f]), clr_in[f]);
      p_in[f] = reset ? 1'b0 : btn_in[f];
      if (f <= W-2) begin
        m_up[f] = req_next(m_up[f], reset, pressed(btn_up[f], p_up[f]), clr_up[f]);
        p_up[f] = reset ? 1'b0 : btn_up[f];
      end
      if (f >= 1) begin
        m_dn[f] = req_next(m_dn[f], reset, pressed(btn_dn[f], p_dn[f]), clr_dn[f]);
        p_dn[f] = reset ? 1'b0 : btn_dn[f];
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] e_in;
    logic [6:0] e_up;
    logic [7:1] e_dn;
    if (cmp_en) begin
      e_in = '0; e_up = '0; e_dn = '0;
      for (int f = 0; f < W; f++) begin
        e_in[f] = m_in[f];
        if (f <= W-2) e_up[f] = m_up[f];
        if (f >= 1)   e_dn[f] = m_dn[f];
      end
      checks++;
      if (act_in !== e_in) begin
        failures++;
        $display("FAIL model_in t=%0t got=%h exp=%h", $time, act_in, e_in);
      end
      checks++;
      if (act_up !== e_up) begin
        failures++;
        $display("FAIL model_up t=%0t got=%h exp=%h", $time, act_up, e_up);
      end
      checks++;
      if (act_dn !== e_dn) begin
        failures++;
        $display("FAIL model_down t=%0t got=%h exp=%h", $time, act_dn, e_dn);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(string name, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic idle();
    btn_in = '0; clr_in = '0; btn_up = '0; clr_up = '0; btn_dn = '0; clr_dn = '0;
  endtask

  initial begin
    logic [7:0] e;
    reset = 1;
    idle();
    tick();
    cmp_en = 1;

    // reset after arbitrary presses
    reset = 0;
    btn_in = 8'hA5; btn_up = 7'h33; btn_dn = 7'h55;
    tick();
    tick();
    reset = 1;
    tick();
    lit("reset_in", act_in, 8'h00);
    lit("reset_up", {1'b0, act_up}, 8'h00);
    lit("reset_dn", {act_dn, 1'b0}, 8'h00);
    reset = 0;
    idle();
    tick();

    // walking one-cycle pulses accumulate
    for (int i = 0; i < 8; i++) begin
      btn_in = 8'(1 << i);
      tick();
      e = 8'((16'd1 << (i + 1)) - 16'd1);
      lit("walk_in", act_in, e);
    end
    btn_in = '0;
    tick();
    for (int i = 0; i < 8; i++) begin
      btn_in = 8'(1 << i);
      tick();
      lit("rewalk_in", act_in, 8'hFF);
    end
    idle();
    tick();

    // clear everything, then staggered set/clear
    clr_in = 8'hFF;
    tick();
    lit("clear_all", act_in, 8'h00);
    for (int t = 0; t < 10; t++) begin
      btn_in = (t < 8) ? 8'(1 << t) : 8'h00;
      clr_in = (t >= 2) ? 8'(1 << (t - 2)) : 8'h00;
      tick();
      if (t == 4) lit("stagger_t4", act_in, 8'h18);
    end
    idle();
    tick();
    lit("stagger_end", act_in, 8'h00);
    btn_in = 8'h20;
    tick();
    lit("repress", act_in, 8'h20);
    idle();
    tick();

    // hall banks
    btn_up = 7'h7F; btn_dn = 7'h7F;
    tick();
    lit("hall_up", {1'b0, act_up}, 8'h7F);
    lit("hall_dn", {act_dn, 1'b0}, 8'hFE);
    lit("hall_in_untouched", act_in, 8'h20);
    idle();
    for (int i = 0; i < 7; i++) begin
      clr_up = 7'(1 << i);
      tick();
      e = 8'h7F & ~8'((16'd1 << (i + 1)) - 16'd1);
      lit("up_drop", {1'b0, act_up}, e);
    end
    lit("dn_kept", {act_dn, 1'b0}, 8'hFE);
    idle();
    for (int i = 1; i < 8; i++) begin
      clr_dn = 7'(1 << (i - 1));
      tick();
      e = 8'hFE & ~8'((16'd1 << (i + 1)) - 16'd1);
      lit("dn_drop", {act_dn, 1'b0}, e);
    end
    idle();
    tick();

    // same-cycle set and clear: clear wins
    btn_in = 8'h08;
    tick();
    lit("pre_simul", act_in, 8'h28);
    btn_in = 8'h08; clr_in = 8'h08;
    tick();
    lit("simul_clr", act_in, 8'h20);
    idle();
    tick();

    // held button across a clear pulse
    btn_in = 8'h04;
    tick();
    lit("held_set", act_in, 8'h24);
    clr_in = 8'h04;
    tick();
    lit("held_clr", act_in, 8'h20);
    clr_in = 8'h00;
    tick();
`ifdef BUTTONS_RES_EDGE_EN
    lit("held_after", act_in, 8'h20);
`else
    lit("held_after", act_in, 8'h24);
`endif
    btn_in = 8'h00;
    clr_in = 8'h04;
    tick();
    clr_in = 8'h00;
    btn_in = 8'h04;
    tick();
    lit("repress_2", act_in, 8'h24);
    idle();
    tick();

    // reset beats simultaneous presses
    btn_in = 8'hFF; btn_up = 7'h7F; btn_dn = 7'h7F;
    reset = 1;
    tick();
    lit("rst_press_in", act_in, 8'h00);
    lit("rst_press_up", {1'b0, act_up}, 8'h00);
    lit("rst_press_dn", {act_dn, 1'b0}, 8'h00);
    reset = 0;
    idle();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
